// File: rtl/cmd_uart_rx.sv
// cmd_uart_rx: 8N1 UART receiver feeding the stats block with command bytes.
//
// Each accepted byte is presented on cmd for HOLD_CYCLES cycles, then cmd is
// forced to 8'h00 for GAP_CYCLES cycles so that the stats block re-arms its
// one-action-per-press latch. A one-entry pending buffer absorbs a byte that
// arrives while a command is still being presented.
//
// Optional build macro:
//   CMD_FILTER_EN  accept only b/d/e/p/s/w (upper-case variants folded to lower
//                  case); otherwise every nonzero byte is passed unchanged.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      synchronous, active-low reset
//   rx         asynchronous serial line, idle high
//   cmd        command byte to stats.inputs, 8'h00 = no command
//   cmd_valid  1-cycle pulse on the first cycle a byte appears on cmd
//   frame_err  1-cycle pulse when the stop bit is sampled low
//   overrun    1-cycle pulse when a byte is dropped because pending is full
//   busy       high while the receive FSM is not idle
module cmd_uart_rx #(
  parameter int unsigned CLK_HZ      = 27000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned HOLD_CYCLES = 1024,
  parameter int unsigned GAP_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] cmd,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned Cpb    = CLK_HZ / BAUD;
  localparam int unsigned TimerW = $clog2(Cpb - 1) + 1;
  localparam int unsigned HoldW  = $clog2(HOLD_CYCLES - 1) + 1;
  localparam int unsigned GapW   = $clog2(GAP_CYCLES - 1) + 1;

  localparam logic [TimerW-1:0] HalfLast = TimerW'(Cpb / 2 - 1);
  localparam logic [TimerW-1:0] FullLast = TimerW'(Cpb - 1);
  localparam logic [HoldW-1:0]  HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [GapW-1:0]   GapLast  = GapW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;
  typedef enum logic [1:0] {OutIdle, OutHold, OutGap} out_state_e;

  // Returns {keep, byte}: keep is low for bytes that must be dropped silently.
  function automatic logic [8:0] filter_byte(input logic [7:0] b);
    logic [7:0] f;
    logic       keep;
`ifdef CMD_FILTER_EN
    f = b;
    if (b inside {8'h42, 8'h44, 8'h45, 8'h50, 8'h53, 8'h57}) f = b | 8'h20;
    keep = f inside {8'h62, 8'h64, 8'h65, 8'h70, 8'h73, 8'h77};
`else
    f    = b;
    keep = (b != 8'h00);
`endif
    return {keep, f};
  endfunction

  // Synchronizer
  logic rx_meta_q, rx_s;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s      <= rx_meta_q;
    end
  end

  // Receive FSM
  rx_state_e         rx_state_q, rx_state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              armed_q, armed_d;
  logic              accept, ferr_d;

  always_comb begin
    rx_state_d = rx_state_q;
    timer_d    = timer_q + TimerW'(1);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    armed_d    = armed_q;
    accept     = 1'b0;
    ferr_d     = 1'b0;
    unique case (rx_state_q)
      StIdle: begin
        timer_d = '0;
        // After a framing error the line must return high before re-arming,
        // so a held break is not taken as a stream of start bits.
        if (rx_s) armed_d = 1'b1;
        if (armed_q && !rx_s) rx_state_d = StStart;
      end
      StStart: begin
        if (timer_q == HalfLast) begin
          timer_d = '0;
          if (rx_s) begin
            rx_state_d = StIdle;
          end else begin
            rx_state_d = StData;
            bit_cnt_d  = 3'd0;
          end
        end
      end
      StData: begin
        if (timer_q == FullLast) begin
          timer_d   = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_state_d = StStop;
        end
      end
      StStop: begin
        if (timer_q == FullLast) begin
          timer_d    = '0;
          rx_state_d = StIdle;
          if (rx_s) begin
            accept = 1'b1;
          end else begin
            ferr_d  = 1'b1;
            armed_d = 1'b0;
          end
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_state_q <= StIdle;
      timer_q    <= '0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      armed_q    <= 1'b1;
      frame_err  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      armed_q    <= armed_d;
      frame_err  <= ferr_d;
    end
  end

  assign busy = (rx_state_q != StIdle);

  // Byte filter, pending buffer and output FSM
  logic [8:0] filt;
  logic       acc_ok;

  assign filt   = filter_byte(shift_q);
  assign acc_ok = accept && filt[8];

  out_state_e       out_state_q, out_state_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             cmd_valid_d, overrun_d, take;

  always_comb begin
    out_state_d  = out_state_q;
    hold_cnt_d   = hold_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    cmd_d        = cmd_q;
    cmd_valid_d  = 1'b0;
    take         = 1'b0;
    unique case (out_state_q)
      OutIdle: begin
        cmd_d = 8'h00;
        if (pend_valid_q) begin
          take        = 1'b1;
          cmd_d       = pend_q;
          cmd_valid_d = 1'b1;
          hold_cnt_d  = '0;
          out_state_d = OutHold;
        end
      end
      OutHold: begin
        if (hold_cnt_q == HoldLast) begin
          cmd_d       = 8'h00;
          gap_cnt_d   = '0;
          out_state_d = OutGap;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      OutGap: begin
        if (gap_cnt_q == GapLast) out_state_d = OutIdle;
        else                      gap_cnt_d   = gap_cnt_q + GapW'(1);
      end
      default: out_state_d = OutIdle;
    endcase

    // A byte accepted while pending is being emptied still fits.
    pend_valid_d = pend_valid_q && !take;
    pend_d       = pend_q;
    overrun_d    = 1'b0;
    if (acc_ok) begin
      if (!pend_valid_q || take) begin
        pend_valid_d = 1'b1;
        pend_d       = filt[7:0];
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_state_q  <= OutIdle;
      hold_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      cmd_q        <= 8'h00;
      pend_q       <= 8'h00;
      pend_valid_q <= 1'b0;
      cmd_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      out_state_q  <= out_state_d;
      hold_cnt_q   <= hold_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      cmd_q        <= cmd_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      cmd_valid    <= cmd_valid_d;
      overrun      <= overrun_d;
    end
  end

  assign cmd = cmd_q;

endmodule

// File: tb/tb_cmd_uart_rx.sv
`timescale 1ns/1ps
module tb_cmd_uart_rx;

  // Short bit period so several frames fit inside one hold window.
  localparam int unsigned ClkHz = 27000000;
  localparam int unsigned Baud  = 1350000;
  localparam int          Cpb   = ClkHz / Baud;
  localparam int          Hold  = 1024;
  localparam int          Gap   = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b0;
  logic [7:0] cmd;
  logic       cmd_valid, frame_err, overrun, busy;

  cmd_uart_rx #(
    .CLK_HZ     (ClkHz),
    .BAUD       (Baud),
    .HOLD_CYCLES(Hold),
    .GAP_CYCLES (Gap)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .cmd      (cmd),
    .cmd_valid(cmd_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input bit ok, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic check_eq(input string name, input int act, input int exp);
    check(name, act == exp, act, exp);
  endtask

  // Scoreboard: shown bytes with the cycle cmd_valid was seen.
  typedef struct {
    logic [7:0] b;
    int         t;
  } show_t;

  show_t exp_q[$];
  show_t act_q[$];
  int    exp_ferr = 0, exp_ovr = 0, act_ferr = 0, act_ovr = 0, stray = 0;

  // Reference model: timeline of a display that is busy HOLD+GAP cycles per
  // byte plus a single waiting slot.
  bit         pend_v = 1'b0;
  logic [7:0] pend_b;
  int         pend_t;
  int         disp_free = 0;

  function automatic logic [8:0] model_filter(input logic [7:0] b);
    logic [7:0] lc;
`ifdef CMD_FILTER_EN
    string allowed = "bdepsw";
    lc = (b >= "A" && b <= "Z") ? b + 8'd32 : b;
    for (int i = 0; i < allowed.len(); i++) if (allowed[i] == lc) return {1'b1, lc};
    return {1'b0, lc};
`else
    lc = b;
    return {b != 8'h00, lc};
`endif
  endfunction

  task automatic model_take();
    int t;
    if (pend_v) begin
      t = ((pend_t > disp_free) ? pend_t : disp_free) + 1;
      exp_q.push_back('{b: pend_b, t: t});
      disp_free = t + Hold + Gap;
      pend_v    = 1'b0;
    end
  endtask

  task automatic model_accept(input logic [7:0] b, input int a);
    logic [8:0] f;
    int         t;
    f = model_filter(b);
    if (!f[8]) return;
    if (pend_v) begin
      t = ((pend_t > disp_free) ? pend_t : disp_free) + 1;
      if (t <= a) begin
        model_take();
      end else begin
        exp_ovr++;
        return;
      end
    end
    pend_v = 1'b1;
    pend_b = f[7:0];
    pend_t = a;
  endtask

  // Monitor: records shows, checks hold length and gap length.
  logic [7:0] mon_cur = 8'h00;
  int         mon_hold = 0, mon_gap = 0;
  bit         mon_in_hold = 1'b0, mon_seen = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      mon_in_hold = 1'b0;
      mon_seen    = 1'b0;
      mon_hold    = 0;
      mon_gap     = 0;
    end else begin
      if (frame_err) act_ferr++;
      if (overrun) act_ovr++;
      if (cmd_valid) begin
        act_q.push_back('{b: cmd, t: cyc});
        if (mon_seen) check("gap_len_min", mon_gap >= Gap, mon_gap, Gap);
        mon_cur     = cmd;
        mon_hold    = 1;
        mon_in_hold = 1'b1;
      end else if (mon_in_hold) begin
        if (cmd == mon_cur) begin
          mon_hold++;
        end else begin
          check_eq("hold_len", mon_hold, Hold);
          check_eq("cmd_after_hold", cmd, 0);
          mon_in_hold = 1'b0;
          mon_seen    = 1'b1;
          mon_gap     = 1;
        end
      end else begin
        if (cmd != 8'h00) stray++;
        mon_gap++;
      end
    end
  end

  task automatic clear_scoreboard();
    model_take();
    exp_q.delete();
    act_q.delete();
    exp_ferr = 0;
    exp_ovr  = 0;
    act_ferr = 0;
    act_ovr  = 0;
    stray    = 0;
  endtask

  // Sends one frame; the model learns the cycle the stop bit is judged.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int idle_after);
    int k, a;
    @(negedge clk);
    k  = cyc;
    rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (Cpb) @(negedge clk);
    end
    rx = stop_ok;
    repeat (Cpb) @(negedge clk);
    rx = 1'b1;
    // 2 sync flops + idle detect, half-bit start check, 8 data bits, stop bit.
    a = k + 3 + Cpb / 2 + 9 * Cpb;
    if (stop_ok) model_accept(b, a);
    else exp_ferr++;
    repeat (idle_after) @(negedge clk);
  endtask

  task automatic check_phase(input string name);
    model_take();
    while (cyc < disp_free + 8) @(negedge clk);
    check_eq({name, "_nshow"}, act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      check_eq($sformatf("%s_byte%0d", name, i), act_q[i].b, exp_q[i].b);
      check_eq($sformatf("%s_time%0d", name, i), act_q[i].t, exp_q[i].t);
    end
    check_eq({name, "_frame_err"}, act_ferr, exp_ferr);
    check_eq({name, "_overrun"}, act_ovr, exp_ovr);
    check_eq({name, "_stray_cmd"}, stray, 0);
    clear_scoreboard();
  endtask

  typedef struct {
    logic [7:0] tx;
    bit         stop_ok;
    logic [7:0] exp_show;
    int         exp_ferr;
  } vec_t;

`ifdef CMD_FILTER_EN
  localparam logic [7:0] Exp41 = 8'h00, Exp45 = 8'h65, Exp57 = 8'h77;
`else
  localparam logic [7:0] Exp41 = 8'h41, Exp45 = 8'h45, Exp57 = 8'h57;
`endif

  vec_t       vecs[8];
  logic [7:0] cmd_chars[6];

  initial begin
    #900_000;
    $display("FAIL watchdog: got cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{tx: 8'h65, stop_ok: 1'b1, exp_show: 8'h65, exp_ferr: 0};
    vecs[1] = '{tx: 8'h73, stop_ok: 1'b0, exp_show: 8'h00, exp_ferr: 1};
    vecs[2] = '{tx: 8'h70, stop_ok: 1'b1, exp_show: 8'h70, exp_ferr: 0};
    vecs[3] = '{tx: 8'h00, stop_ok: 1'b1, exp_show: 8'h00, exp_ferr: 0};
    vecs[4] = '{tx: 8'h41, stop_ok: 1'b1, exp_show: Exp41, exp_ferr: 0};
    vecs[5] = '{tx: 8'h45, stop_ok: 1'b1, exp_show: Exp45, exp_ferr: 0};
    vecs[6] = '{tx: 8'h57, stop_ok: 1'b1, exp_show: Exp57, exp_ferr: 0};
    vecs[7] = '{tx: 8'h62, stop_ok: 1'b1, exp_show: 8'h62, exp_ferr: 0};
    cmd_chars = '{8'h62, 8'h64, 8'h65, 8'h70, 8'h73, 8'h77};

    // Reset with the line held low.
    reset = 1'b0;
    rx    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    check_eq("reset_cmd", cmd, 0);
    check_eq("reset_cmd_valid", cmd_valid, 0);
    check_eq("reset_frame_err", frame_err, 0);
    check_eq("reset_overrun", overrun, 0);
    check_eq("reset_busy", busy, 0);
    repeat (10) @(negedge clk);

    // Table: single bytes, framing error, zero byte, case folding.
    for (int i = 0; i < 8; i++) begin
      clear_scoreboard();
      send_byte(vecs[i].tx, vecs[i].stop_ok, 4);
      repeat (Hold + Gap + 20) @(negedge clk);
      check_eq($sformatf("vec%0d_nshow", i), act_q.size(), (vecs[i].exp_show != 0) ? 1 : 0);
      if (act_q.size() > 0 && vecs[i].exp_show != 0)
        check_eq($sformatf("vec%0d_cmd", i), act_q[0].b, vecs[i].exp_show);
      check_eq($sformatf("vec%0d_frame_err", i), act_ferr, vecs[i].exp_ferr);
      check_eq($sformatf("vec%0d_overrun", i), act_ovr, 0);
      check_eq($sformatf("vec%0d_cmd_idle", i), cmd, 0);
      check_eq($sformatf("vec%0d_stray", i), stray, 0);
    end
    clear_scoreboard();

    // Start-bit glitch shorter than half a bit.
    @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("glitch_busy_in_start", busy, 1);
    @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("glitch_busy_after", busy, 0);
    repeat (300) @(negedge clk);
    check_phase("glitch");

    // Three back-to-back bytes inside one hold window.
    send_byte(8'h62, 1'b1, 0);
    send_byte(8'h64, 1'b1, 0);
    send_byte(8'h77, 1'b1, 0);
    repeat (2 * (Hold + Gap) + 20) @(negedge clk);
    check_eq("b2b_nshow", act_q.size(), 2);
    if (act_q.size() == 2) begin
      check_eq("b2b_first", act_q[0].b, 8'h62);
      check_eq("b2b_second", act_q[1].b, 8'h64);
      check("b2b_second_after_gap", act_q[1].t - act_q[0].t >= Hold + Gap,
            act_q[1].t - act_q[0].t, Hold + Gap);
    end
    check_eq("b2b_overrun", act_ovr, 1);
    check_phase("b2b");

    // Reset in the middle of a frame of 8'h65 (after bit 3).
    @(negedge clk);
    rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0 || i == 2) ? 1'b1 : 1'b0;
      repeat (Cpb) @(negedge clk);
    end
    check_eq("midreset_busy_before", busy, 1);
    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    reset  = 1'b1;
    pend_v = 1'b0;
    @(negedge clk);
    check_eq("midreset_busy_after", busy, 0);
    check_eq("midreset_cmd", cmd, 0);
    send_byte(8'h64, 1'b1, 10);
    check_phase("midreset");

    // Random traffic against the timeline model.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      bit         ok;
      int         idle;
      case ($urandom_range(0, 3))
        0:       b = cmd_chars[$urandom_range(0, 5)];
        1:       b = cmd_chars[$urandom_range(0, 5)] & 8'hdf;
        default: b = 8'($urandom_range(0, 255));
      endcase
      ok   = ($urandom_range(0, 5) != 0);
      idle = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 30) : $urandom_range(300, 1500);
      if (!ok && idle < 4) idle = 4;
      send_byte(b, ok, idle);
    end
    check_phase("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
